// File: rtl/shared_pkg.sv
// ============================================================================
//  Module   : shared_pkg
//  Brief    : Shared word type and width helpers for the FIFO read adapter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package shared_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_BUF_DEPTH  = 2;

    typedef logic [DEF_FIFO_WIDTH-1:0] word_t;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_out_buf.sv
// ============================================================================
//  Module   : fifo_rd_out_buf
//  Brief    : Small circular output buffer with push/pop and stream outputs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_out_buf
    import shared_pkg::*;
#(
    parameter  int WIDTH = DEF_FIFO_WIDTH,
    parameter  int DEPTH = DEF_BUF_DEPTH,
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Storage is cleared too so the head word reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign valid = (occ != '0);
    assign data  = mem[head];

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream_adapter.sv
// ============================================================================
//  Module   : fifo_rd_stream_adapter
//  Brief    : Credit-limited FIFO reader presenting a valid/ready stream.
//             Optional sticky underflow flag: FIFO_RD_UNDERFLOW_CHK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream_adapter
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  err_underflow
);

    localparam int OCC_W = occ_width(BUF_DEPTH);
    localparam int CRD_W = OCC_W + 1;

    logic             inflight_q;
    logic [OCC_W-1:0] occ;
    logic             pop;
    logic             capture;
    logic [CRD_W-1:0] credit_used;

    assign pop     = m_valid && m_ready;
    assign capture = inflight_q && !fifo_underflow;

    // A word popped this cycle frees its slot in time for a read issued now.
    assign credit_used = CRD_W'(occ) + CRD_W'(inflight_q) - CRD_W'(pop);
    assign fifo_rd_en  = !rst && en && !fifo_empty && (credit_used < CRD_W'(BUF_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (inflight_q && fifo_underflow) begin
            err_underflow <= 1'b1;
        end
    end
`else
    assign err_underflow = 1'b0;
`endif

    fifo_rd_out_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .valid     (m_valid),
        .data      (m_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream_adapter.sv
// ============================================================================
//  Module   : tb_fifo_rd_stream_adapter
//  Brief    : Scoreboard bench with a behavioural FIFO feeding the adapter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream_adapter;

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    localparam logic UF_EN = 1'b1;
`else
    localparam logic UF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        fifo_empty = 1'b0;
    logic        fifo_underflow = 1'b0;
    logic [15:0] fifo_data_out = 16'h0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        err_underflow;

    logic [15:0] fifo_q [$];
    logic [15:0] load_q [$];
    logic [15:0] exp_q  [$];
    logic        force_uf = 1'b0;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int deliv_cnt = 0;

    fifo_rd_stream_adapter #(
        .FIFO_WIDTH (16),
        .BUF_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural FIFO: registered read data/underflow; force_uf fakes a bad read.
    always @(posedge clk) begin
        fifo_underflow <= 1'b0;
        if (fifo_rd_en) begin
            if (force_uf || fifo_q.size() == 0) fifo_underflow <= 1'b1;
            else fifo_data_out <= fifo_q.pop_front();
        end
        while (load_q.size() > 0) fifo_q.push_back(load_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt++;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("sb_extra_word", {16'h0, m_data}, 32'hFFFF_FFFF);
            else chk("sb_data", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
            deliv_cnt++;
        end
    end

    task automatic load(input logic [15:0] w);
        load_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        logic [5:0]  rd_pat;
        logic [5:0]  v_pat;
        logic [3:0]  v5;
        logic [15:0] first;
        int          c0;
        int          d0;

        // T1: outputs clear during reset with a non-empty FIFO and en high
        en = 1'b1;
        m_ready = 1'b1;
        load(16'h0BAD);
        #1;
        chk("t1_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("t1_valid", 32'(m_valid), 32'd0);
        chk("t1_data", 32'(m_data), 32'd0);
        chk("t1_err", 32'(err_underflow), 32'd0);
        tick();
        rst = 1'b0;
        drain(20);

        // T2: back-to-back throughput and two-cycle latency
        en = 1'b0;
        load(16'hA001); load(16'hA002); load(16'hA003);
        tick(); tick();
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_pat[i] = fifo_rd_en;
            v_pat[i]  = m_valid;
        end
        chk("t2_rd_pattern", 32'(rd_pat), 32'b000111);
        chk("t2_valid_pattern", 32'(v_pat), 32'b011100);
        drain(20);

        // T3: backpressure limits reads to the buffer depth, head word held
        en = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) load(16'hB000 + 16'(i));
        tick(); tick();
        c0 = rd_cnt;
        en = 1'b1;
        repeat (8) tick();
        chk("t3_rd_count", 32'(rd_cnt - c0), 32'd2);
        chk("t3_valid", 32'(m_valid), 32'd1);
        first = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold", 32'(m_data), 32'(first));
        end
        tick();
        m_ready = 1'b1;
        drain(30);

        // T4: en dropped after one read; the in-flight word still arrives
        en = 1'b0;
        load(16'hC001); load(16'hC002); load(16'hC003);
        tick(); tick();
        c0 = rd_cnt;
        d0 = deliv_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (8) tick();
        chk("t4_rd_count", 32'(rd_cnt - c0), 32'd1);
        chk("t4_delivered", 32'(deliv_cnt - d0), 32'd1);
        chk("t4_left", 32'(exp_q.size()), 32'd2);
        en = 1'b1;
        drain(20);

        // T5: underflow on a capture cycle drops the word and may flag an error
        en = 1'b0;
        load(16'hD001); load(16'hD002);
        tick(); tick();
        force_uf = 1'b1;
        en = 1'b1;
        @(negedge clk);
        v5[0] = m_valid;
        tick();
        force_uf = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            v5[i] = m_valid;
        end
        chk("t5_valid_pattern", 32'(v5), 32'b1000);
        chk("t5_err", 32'(err_underflow), 32'(UF_EN));
        drain(20);
        chk("t5_err_sticky", 32'(err_underflow), 32'(UF_EN));

        // T6: asynchronous reset mid-stream discards buffered and in-flight words
        en = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) load(16'hE000 + 16'(i));
        tick(); tick();
        en = 1'b1;
        tick(); tick();
        chk("t6_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("t6_valid", 32'(m_valid), 32'd0);
        chk("t6_data", 32'(m_data), 32'd0);
        chk("t6_err", 32'(err_underflow), 32'd0);
        exp_q = fifo_q;
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        d0 = deliv_cnt;
        drain(30);
        chk("t6_delivered", 32'(deliv_cnt - d0), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
